// File: rtl/agu_addr_mod.sv
// agu_addr_mod: address-modifier arithmetic stage of the AGU.
// Takes one R/N/M operand triple plus an addressing-mode op per transaction.
// Produces the effective address and the updated R value. The M value selects
// one of three arithmetic kinds:
//   M = all ones or MSB set    : linear
//   M = 0                      : reverse-carry
//   otherwise                  : modulo M+1
// Two-stage pipeline with valid/ready on both sides.
//   Stage 1 registers the operands, the signed step, the k-mask and the raw sum.
//   Stage 2 applies wrap correction / reverse-carry and registers the outputs.
// Ports:
//   Clk, reset                   clock (rising edge), async active-high reset
//   in_valid/in_ready            upstream handshake
//   op[2:0], r_in, n_in, m_in    mode code and operand triple
//   out_valid/out_ready          downstream handshake
//   ea_out, r_out                effective address, updated R
//   mod_err (AGU_MOD_ERR_EN)     M in 8000..FFFE, or modulo step larger than M+1
// Optional feature macro: AGU_MOD_ERR_EN adds the mod_err output.
module agu_addr_mod #(
  parameter int unsigned AW = 16
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] r_in,
  input  logic [AW-1:0] n_in,
  input  logic [AW-1:0] m_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] ea_out,
`ifdef AGU_MOD_ERR_EN
  output logic [AW-1:0] r_out,
  output logic          mod_err
`else
  output logic [AW-1:0] r_out
`endif
);

  // Two guard bits: -N for N = 8000 needs +2^15, and R + S must not overflow.
  localparam int unsigned SW = AW + 2;

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] res;
    for (int i = 0; i < int'(AW); i++) res[i] = v[AW-1-i];
    return res;
  endfunction

  // ---------------- Stage 1 ----------------
  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           s1_op_q;
  logic [AW-1:0]        s1_r_q, s1_m_q, s1_mask_q;
  logic signed [SW-1:0] s1_step_q, s1_sum_q;

  logic                 s1_adv, in_fire;
  logic signed [SW-1:0] step, sum, n_ext;
  logic [AW-1:0]        mask;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    n_ext = {{2{n_in[AW-1]}}, n_in};
    step  = '0;
    unique case (op)
      3'b001:          step = SW'(1);
      3'b010, 3'b110:  step = -SW'(1);
      3'b011, 3'b101:  step = n_ext;
      3'b100:          step = -n_ext;
      default:         step = '0;
    endcase
    sum = $signed({2'b00, r_in}) + step;
  end

  // Smear M downward: low k bits set, where 2^k is the smallest power above M.
  always_comb begin
    mask = '0;
    mask[AW-1] = m_in[AW-1];
    for (int i = int'(AW) - 2; i >= 0; i--) mask[i] = mask[i+1] | m_in[i];
  end

  assign s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_r_q     <= '0;
      s1_m_q     <= '0;
      s1_mask_q  <= '0;
      s1_step_q  <= '0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_op_q   <= op;
        s1_r_q    <= r_in;
        s1_m_q    <= m_in;
        s1_mask_q <= mask;
        s1_step_q <= step;
        s1_sum_q  <= sum;
      end
    end
  end

  // ---------------- Stage 2 ----------------
  logic                 out_valid_q, out_valid_d;
  logic [AW-1:0]        ea_q, ea_d, r_q, r_d;
  logic [AW-1:0]        base, mod_val, rc_val;
  logic signed [SW-1:0] upper, m_plus1;
  logic                 is_rev, is_lin;

  always_comb begin
    base    = s1_r_q & ~s1_mask_q;
    upper   = $signed({2'b00, base}) + $signed({2'b00, s1_m_q});
    m_plus1 = $signed({2'b00, s1_m_q}) + SW'(1);
    is_rev  = (s1_m_q == '0);
    is_lin  = s1_m_q[AW-1];
    rc_val  = bit_rev(bit_rev(s1_r_q) + bit_rev(s1_step_q[AW-1:0]));
    mod_val = s1_sum_q[AW-1:0];
    if (is_rev) begin
      mod_val = rc_val;
    end else if (!is_lin) begin
      // Single correction only: a step larger than the window is not re-wrapped.
      if (!s1_step_q[SW-1] && (s1_sum_q > upper)) begin
        mod_val = AW'(s1_sum_q - m_plus1);
      end else if (s1_step_q[SW-1] && (s1_sum_q < $signed({2'b00, base}))) begin
        mod_val = AW'(s1_sum_q + m_plus1);
      end
    end
  end

  always_comb begin
    ea_d = s1_r_q;
    r_d  = s1_r_q;
    unique case (s1_op_q)
      3'b001, 3'b010, 3'b011, 3'b100: r_d = mod_val;
      3'b101:  ea_d = mod_val;
      3'b110: begin
        ea_d = mod_val;
        r_d  = mod_val;
      end
      default: ;
    endcase
  end

  assign out_valid_d = s1_adv ? s1_valid_q : out_valid_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ea_q        <= '0;
      r_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s1_adv && s1_valid_q) begin
        ea_q <= ea_d;
        r_q  <= r_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ea_out    = ea_q;
  assign r_out     = r_q;

`ifdef AGU_MOD_ERR_EN
  logic                 err_q, err_d;
  logic signed [SW-1:0] step_abs;

  always_comb begin
    step_abs = s1_step_q[SW-1] ? -s1_step_q : s1_step_q;
    err_d    = 1'b0;
    if (is_lin && (s1_m_q != '1)) begin
      err_d = 1'b1;
    end else if (!is_lin && !is_rev && (step_abs > m_plus1)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (s1_adv && s1_valid_q) begin
      err_q <= err_d;
    end
  end

  assign mod_err = err_q;
`endif

endmodule

// File: tb/tb_agu_addr_mod.sv
// Directed bench for agu_addr_mod: hand-computed vectors for each arithmetic
// kind, a backpressure sequence and an asynchronous reset mid-stream.
module tb_agu_addr_mod;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [15:0] r_in = '0, n_in = '0, m_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] ea_out, r_out;
`ifdef AGU_MOD_ERR_EN
  logic        mod_err;
`endif

  int checks = 0;
  int errors = 0;

  agu_addr_mod #(.AW(16)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .r_in      (r_in),
    .n_in      (n_in),
    .m_in      (m_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ea_out    (ea_out),
`ifdef AGU_MOD_ERR_EN
    .r_out     (r_out),
    .mod_err   (mod_err)
`else
    .r_out     (r_out)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] r, input logic [15:0] n,
                       input logic [15:0] m);
    op = o; r_in = r; n_in = n; m_in = m; in_valid = 1'b1;
  endtask

  // One isolated transaction with out_ready held high.
  task automatic run_one(input string tag, input logic [2:0] o, input logic [15:0] r,
                         input logic [15:0] n, input logic [15:0] m,
                         input logic [15:0] exp_ea, input logic [15:0] exp_r,
                         input logic exp_err);
    logic seen;
    @(negedge Clk);
    drive(o, r, n, m);
    out_ready = 1'b1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq({tag, "_out_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, "_ea"}, 32'(ea_out), 32'(exp_ea));
      check_eq({tag, "_r"}, 32'(r_out), 32'(exp_r));
`ifdef AGU_MOD_ERR_EN
      check_eq({tag, "_mod_err"}, 32'(mod_err), 32'(exp_err));
`else
      if (exp_err) begin end
`endif
    end
    @(posedge Clk);
    #1;
  endtask

  // Backpressure vectors, all linear (M = FFFF).
  logic [2:0]  bp_op [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
  logic [15:0] bp_r  [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  logic [15:0] bp_n  [4] = '{16'h0000, 16'h0000, 16'h0010, 16'h0020};
  logic [15:0] bp_ea [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0420};
  logic [15:0] bp_ro [4] = '{16'h0101, 16'h01FF, 16'h0310, 16'h0400};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, got;
    logic in_fire, out_fire;

    #1;
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_ea", 32'(ea_out), 32'd0);
    check_eq("reset_r", 32'(r_out), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;

    run_one("linear",    3'b011, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    run_one("mod_up",    3'b001, 16'h0025, 16'h0000, 16'h0005, 16'h0025, 16'h0020, 1'b0);
    run_one("mod_down",  3'b010, 16'h0020, 16'h0000, 16'h0005, 16'h0020, 16'h0025, 1'b0);
    run_one("mod_minus", 3'b100, 16'h0041, 16'h0003, 16'h0009, 16'h0041, 16'h0048, 1'b0);
    run_one("indexed",   3'b101, 16'h0047, 16'h0004, 16'h0009, 16'h0041, 16'h0047, 1'b0);
    run_one("rev_0",     3'b011, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0010, 1'b0);
    run_one("rev_1",     3'b011, 16'h0010, 16'h0010, 16'h0000, 16'h0010, 16'h0008, 1'b0);
    run_one("rev_2",     3'b011, 16'h0008, 16'h0010, 16'h0000, 16'h0008, 16'h0018, 1'b0);
    run_one("predec",    3'b110, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    run_one("reserved",  3'b111, 16'h1234, 16'h5678, 16'h0005, 16'h1234, 16'h1234, 1'b0);
    run_one("nop",       3'b000, 16'h0027, 16'h0000, 16'h0005, 16'h0027, 16'h0027, 1'b0);
    run_one("big_m",     3'b001, 16'h1234, 16'h0000, 16'h8000, 16'h1234, 16'h1235, 1'b1);
    run_one("overstep",  3'b011, 16'h0021, 16'h0007, 16'h0005, 16'h0021, 16'h0022, 1'b1);

    // Backpressure: out_ready low for cycles 0..3.
    @(negedge Clk);
    out_ready = 1'b0;
    drive(bp_op[0], bp_r[0], bp_n[0], 16'hFFFF);
    sent = 0;
    got  = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge Clk);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (c <= 1) check_eq("bp_accept", 32'(in_ready), 32'd1);
      if (c == 2 || c == 3) begin
        check_eq("bp_stall_ready", 32'(in_ready), 32'd0);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_ea", 32'(ea_out), 32'h0100);
        check_eq("bp_hold_r", 32'(r_out), 32'h0101);
      end
      if (out_fire) begin
        if (got < 4) begin
          check_eq("bp_ea", 32'(ea_out), 32'(bp_ea[got]));
          check_eq("bp_r", 32'(r_out), 32'(bp_ro[got]));
        end
        got++;
      end
      @(posedge Clk);
      #1;
      if (in_fire) begin
        sent++;
        if (sent < 4) drive(bp_op[sent], bp_r[sent], bp_n[sent], 16'hFFFF);
        else in_valid = 1'b0;
      end
      out_ready = (c >= 3);
    end
    check_eq("bp_count", 32'(got), 32'd4);

    // Async reset with two transactions in flight.
    @(negedge Clk);
    out_ready = 1'b0;
    drive(3'b001, 16'h0500, 16'h0000, 16'hFFFF);
    @(posedge Clk);
    #1 drive(3'b001, 16'h0600, 16'h0000, 16'hFFFF);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    check_eq("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("async_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_ea", 32'(ea_out), 32'd0);
    check_eq("async_r", 32'(r_out), 32'd0);
    check_eq("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge Clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_eq("no_stale", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
